// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: boot-time sequencer that freezes each core, writes its id, CCE mode and CCE ucode, then unfreezes all cores.
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   start_i                  begin a load sequence (ignored while busy_o)
//   cce_mode_i, skip_ucode_i CCE mode value and ucode-skip flag, captured at start
//   ucode_v_o/addr_o/data_i  ucode ROM read port, data returns one cycle after the strobe
//   cfg_v_o/core_o/addr_o/data_o, cfg_ready_i  config write port, transfer = cfg_v_o & cfg_ready_i
//   busy_o, done_o           sequence status
module bp_cfg_loader #(
    parameter int num_core_p              = 1,
    parameter int cfg_core_width_p        = 8,
    parameter int cfg_addr_width_p        = 16,
    parameter int cfg_data_width_p        = 32,
    parameter int num_cce_instr_ram_els_p = 256
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       start_i,
    input  logic                                       cce_mode_i,
    input  logic                                       skip_ucode_i,
    output logic                                       ucode_v_o,
    output logic [$clog2(num_cce_instr_ram_els_p)-1:0] ucode_addr_o,
    input  logic [cfg_data_width_p-1:0]                ucode_data_i,
    output logic                                       cfg_v_o,
    output logic [cfg_core_width_p-1:0]                cfg_core_o,
    output logic [cfg_addr_width_p-1:0]                cfg_addr_o,
    output logic [cfg_data_width_p-1:0]                cfg_data_o,
    input  logic                                       cfg_ready_i,
    output logic                                       busy_o,
    output logic                                       done_o
);
    localparam int iw = $clog2(num_cce_instr_ram_els_p);
    localparam int cw = num_core_p > 1 ? $clog2(num_core_p) : 1;
    localparam logic [cw-1:0] last_core = cw'(num_core_p - 1);
    localparam logic [iw-1:0] last_idx = iw'(num_cce_instr_ram_els_p - 1);
    localparam logic [cfg_addr_width_p-1:0] addr_freeze = cfg_addr_width_p'(16'h0001);
    localparam logic [cfg_addr_width_p-1:0] addr_core_id = cfg_addr_width_p'(16'h0002);
    localparam logic [cfg_addr_width_p-1:0] addr_cce_mode = cfg_addr_width_p'(16'h0003);
    localparam logic [cfg_addr_width_p-1:0] addr_ucode = cfg_addr_width_p'(16'h8000);

    typedef enum logic [2:0] {IDLE, FREEZE, CORE_ID, CCE_MODE, UCODE_RD, UCODE_WR, UNFREEZE, DONE} state_t;

    state_t                      state, state_n, after_core;
    logic [cw-1:0]               core, core_n, core_adv;
    logic [iw-1:0]               idx, idx_n;
    logic                        mode, skip, first;
    logic [cfg_data_width_p-1:0] hold;
    logic                        xfer, last_c, start_ok;

    assign xfer       = cfg_v_o & cfg_ready_i;
    assign last_c     = core == last_core;
    assign start_ok   = (state == IDLE || state == DONE) && start_i;
    assign core_adv   = last_c ? '0 : core + cw'(1);
    assign after_core = last_c ? UNFREEZE : FREEZE;

    // first marks the UCODE_WR entry cycle, the only cycle the ROM data is valid;
    // it is written straight through and kept in hold for any stalled cycles.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            core  <= '0;
            idx   <= '0;
            mode  <= 1'b0;
            skip  <= 1'b0;
            first <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_n;
            core  <= core_n;
            idx   <= idx_n;
            first <= state == UCODE_RD;
            if (first) hold <= ucode_data_i;
            if (start_ok) begin
                mode <= cce_mode_i;
                skip <= skip_ucode_i;
            end
        end
    end

    always_comb begin
        state_n = state;
        core_n  = core;
        idx_n   = idx;
        case (state)
            IDLE, DONE: if (start_i) begin
                state_n = FREEZE;
                core_n  = '0;
                idx_n   = '0;
            end
            FREEZE:   if (xfer) state_n = CORE_ID;
            CORE_ID:  if (xfer) state_n = CCE_MODE;
            CCE_MODE: if (xfer) begin
                state_n = skip ? after_core : UCODE_RD;
                core_n  = skip ? core_adv : core;
            end
            UCODE_RD: state_n = UCODE_WR;
            UCODE_WR: if (xfer) begin
                if (idx != last_idx) begin
                    idx_n   = idx + iw'(1);
                    state_n = UCODE_RD;
                end else begin
                    idx_n   = '0;
                    state_n = after_core;
                    core_n  = core_adv;
                end
            end
            UNFREEZE: if (xfer) begin
                state_n = last_c ? DONE : UNFREEZE;
                core_n  = core_adv;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cfg_v_o      = state inside {FREEZE, CORE_ID, CCE_MODE, UCODE_WR, UNFREEZE};
        ucode_v_o    = state == UCODE_RD;
        ucode_addr_o = state == UCODE_RD ? idx : '0;
        cfg_core_o   = cfg_v_o ? cfg_core_width_p'(core) : '0;
        busy_o       = !(state == IDLE || state == DONE);
        done_o       = state == DONE;
        cfg_addr_o   = '0;
        cfg_data_o   = '0;
        case (state)
            FREEZE: begin
                cfg_addr_o = addr_freeze;
                cfg_data_o = cfg_data_width_p'(1);
            end
            CORE_ID: begin
                cfg_addr_o = addr_core_id;
                cfg_data_o = cfg_data_width_p'(core);
            end
            CCE_MODE: begin
                cfg_addr_o = addr_cce_mode;
                cfg_data_o = cfg_data_width_p'(mode);
            end
            UCODE_WR: begin
                cfg_addr_o = addr_ucode | cfg_addr_width_p'(idx);
                cfg_data_o = first ? ucode_data_i : hold;
            end
            UNFREEZE: cfg_addr_o = addr_freeze;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb_bp_cfg_loader: table-driven check of the config loader on a 2-core/4-entry and a 1-core/2-entry instance.
module tb_bp_cfg_loader;
    typedef struct packed {
        logic [7:0]  core;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, mode = 1'b0, skip = 1'b0, ready = 1'b1;
    logic        uv, cv, busy, done;
    logic [1:0]  ua;
    logic [31:0] ud = '0, cd;
    logic [7:0]  cc;
    logic [15:0] ca;
    logic        start2 = 1'b0, mode2 = 1'b0, skip2 = 1'b0, ready2 = 1'b1;
    logic        uv2, cv2, busy2, done2;
    logic [0:0]  ua2;
    logic [31:0] ud2 = '0, cd2;
    logic [7:0]  cc2;
    logic [15:0] ca2;
    int          total = 0, pass_cnt = 0, wcnt = 0;
    wr_t         exp_full[16], exp_skip[8], exp_small[6];

    always #5 clk = ~clk;

    bp_cfg_loader #(.num_core_p(2), .num_cce_instr_ram_els_p(4)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .cce_mode_i(mode), .skip_ucode_i(skip),
        .ucode_v_o(uv), .ucode_addr_o(ua), .ucode_data_i(ud),
        .cfg_v_o(cv), .cfg_core_o(cc), .cfg_addr_o(ca), .cfg_data_o(cd), .cfg_ready_i(ready),
        .busy_o(busy), .done_o(done));

    bp_cfg_loader #(.num_core_p(1), .num_cce_instr_ram_els_p(2)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start2), .cce_mode_i(mode2), .skip_ucode_i(skip2),
        .ucode_v_o(uv2), .ucode_addr_o(ua2), .ucode_data_i(ud2),
        .cfg_v_o(cv2), .cfg_core_o(cc2), .cfg_addr_o(ca2), .cfg_data_o(cd2), .cfg_ready_i(ready2),
        .busy_o(busy2), .done_o(done2));

    function automatic logic [31:0] rom(input int a);
        return 32'hC0DE_0000 + 32'(a) * 32'h111;
    endfunction

    // ROM data is valid only the cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        ud   <= uv ? rom(int'(ua)) : 32'hDEAD_BEEF;
        ud2  <= uv2 ? rom(int'(ua2)) : 32'hDEAD_BEEF;
        wcnt <= wcnt + ((cv && ready) ? 1 : 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_seq(input bit sk, input bit md, input int exp_done, input int pulse_at);
        int n, cyc, first_v, uvc, lim;
        n = 0; first_v = -1; uvc = 0;
        lim = sk ? 8 : 16;
        @(negedge clk); start = 1'b1; mode = md; skip = sk;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (!done && cyc < 300) begin
            start = (cyc == pulse_at || cyc == pulse_at + 7);
            if (cv && first_v < 0) first_v = cyc;
            if (uv) uvc++;
            if (cv && ready) begin
                if (n < lim) chk($sformatf("write%0d_skip%0d", n, sk), {cc, ca, cd}, sk ? exp_skip[n] : exp_full[n]);
                n++;
            end
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        chk("done_cycle", 64'(cyc), 64'(exp_done));
        chk("write_count", 64'(n), 64'(lim));
        chk("first_write_cycle", 64'(first_v), 64'd1);
        chk("rom_reads", 64'(uvc), sk ? 64'd0 : 64'd8);
    endtask

    initial begin
        int k, t, p, w0, n, cyc;
        wr_t snap;
        k = 0;
        for (int c = 0; c < 2; c++) begin
            exp_full[k++] = '{8'(c), 16'h0001, 32'h1};
            exp_full[k++] = '{8'(c), 16'h0002, 32'(c)};
            exp_full[k++] = '{8'(c), 16'h0003, 32'h0};
            for (int i = 0; i < 4; i++) exp_full[k++] = '{8'(c), 16'h8000 | 16'(i), rom(i)};
        end
        exp_full[14] = '{8'd0, 16'h0001, 32'h0};
        exp_full[15] = '{8'd1, 16'h0001, 32'h0};
        for (int c = 0; c < 2; c++) begin
            exp_skip[3*c]     = '{8'(c), 16'h0001, 32'h1};
            exp_skip[3*c + 1] = '{8'(c), 16'h0002, 32'(c)};
            exp_skip[3*c + 2] = '{8'(c), 16'h0003, 32'h1};
        end
        exp_skip[6] = '{8'd0, 16'h0001, 32'h0};
        exp_skip[7] = '{8'd1, 16'h0001, 32'h0};
        exp_small[0] = '{8'd0, 16'h0001, 32'h1};
        exp_small[1] = '{8'd0, 16'h0002, 32'h0};
        exp_small[2] = '{8'd0, 16'h0003, 32'h1};
        exp_small[3] = '{8'd0, 16'h8000, rom(0)};
        exp_small[4] = '{8'd0, 16'h8001, rom(1)};
        exp_small[5] = '{8'd0, 16'h0001, 32'h0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({cv, uv, ua, cc, ca, cd, busy, done}), 64'd0);
        rst_n = 1'b1;
        t = 0;
        repeat (5) begin @(negedge clk); t += int'(cv | busy | uv); end
        chk("idle_without_start", 64'(t), 64'd0);

        run_seq(1'b0, 1'b0, 25, -100);
        @(negedge clk);
        chk("done_holds", 64'({done, busy, cv}), 64'b100);
        run_seq(1'b1, 1'b1, 9, -100);
        run_seq(1'b0, 1'b0, 25, 4);

        // stall the core0 ucode index 2 write for three cycles
        w0 = wcnt;
        @(negedge clk); start = 1'b1; mode = 1'b0; skip = 1'b0;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (!(cv && ca == 16'h8002) && t < 100) begin @(negedge clk); t++; end
        chk("reach_ucode2", 64'(t < 100), 64'd1);
        snap = '{cc, ca, cd};
        ready = 1'b0;
        chk("stall_entry_data", 64'(cd), 64'(rom(2)));
        repeat (3) begin
            @(negedge clk);
            chk("stall_stable", 64'({cv, cc, ca, cd}), 64'({1'b1, snap}));
            chk("stall_no_reread", 64'(uv), 64'd0);
        end
        ready = 1'b1;
        t = 0;
        while (!done && t < 100) begin @(negedge clk); t++; end
        chk("stall_done", 64'(done), 64'd1);
        chk("stall_write_count", 64'(wcnt - w0), 64'd16);

        // reset during core1's first UCODE_RD
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0; p = 0;
        while (t < 200) begin
            if (uv) p++;
            if (uv && p == 5) break;
            @(negedge clk); t++;
        end
        chk("reset_point_core1_rd", 64'(p), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({cv, uv, ua, cc, ca, cd, busy, done}), 64'd0);
        @(negedge clk);
        chk("reset_held_outputs", 64'({cv, uv, ua, cc, ca, cd, busy, done}), 64'd0);
        rst_n = 1'b1;
        t = 0;
        repeat (4) begin @(negedge clk); t += int'(cv | busy | uv); end
        chk("post_reset_idle", 64'(t), 64'd0);
        run_seq(1'b0, 1'b0, 25, -100);

        // single core, two ucode entries, cce_mode = 1
        @(negedge clk); start2 = 1'b1; mode2 = 1'b1;
        @(negedge clk); start2 = 1'b0; cyc = 1; n = 0;
        while (!done2 && cyc < 100) begin
            if (cv2 && ready2) begin
                if (n < 6) chk($sformatf("small_write%0d", n), {cc2, ca2, cd2}, exp_small[n]);
                n++;
            end
            @(negedge clk); cyc++;
        end
        chk("small_write_count", 64'(n), 64'd6);
        chk("small_done_cycle", 64'(cyc), 64'd9);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
